// File: rtl/if_id_queue.sv
// if_id_queue: DEPTH-entry FIFO between fetch and decode, valid/ready both sides.
// Optional macro IF_ID_QUEUE_EXC_EN adds a per-entry fetch exception code.
module if_id_queue #(
    parameter int              PC_W     = 32,
    parameter int              INSTR_W  = 32,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h00003000)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         F_valid,
    output logic                         F_ready,
    input  logic [PC_W-1:0]              F_pc,
    input  logic [INSTR_W-1:0]           F_nInstr,
`ifdef IF_ID_QUEUE_EXC_EN
    input  logic [4:0]                   F_exc,
    output logic [4:0]                   exc_D,
`endif
    output logic                         D_valid,
    input  logic                         D_ready,
    output logic [PC_W-1:0]              pc_D,
    output logic [PC_W-1:0]              pcPlus4_D,
    output logic [PC_W-1:0]              pcPlus8_D,
    output logic [INSTR_W-1:0]           nInstr_D,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PC_W-1:0]    last_pc_q, last_pc_d;
    logic [PC_W-1:0]    pc_mem_q [DEPTH];
    logic [PC_W-1:0]    pc_mem_d [DEPTH];
    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [INSTR_W-1:0] instr_mem_d [DEPTH];
    logic [INSTR_W-1:0] wr_instr;
`ifdef IF_ID_QUEUE_EXC_EN
    logic [4:0]         exc_mem_q [DEPTH];
    logic [4:0]         exc_mem_d [DEPTH];
`endif
    logic               push;
    logic               pop;

    // Handshake flags and the registered head presented to decode
    always_comb begin
        F_ready   = (count_q != CW'(DEPTH));
        D_valid   = (count_q != '0);
        push      = F_valid & F_ready;
        pop       = D_valid & D_ready;
        count     = count_q;
        pc_D      = D_valid ? pc_mem_q[rd_ptr_q] : last_pc_q;
        nInstr_D  = D_valid ? instr_mem_q[rd_ptr_q] : '0;
        pcPlus4_D = pc_D + PC_W'(4);
        pcPlus8_D = pc_D + PC_W'(8);
`ifdef IF_ID_QUEUE_EXC_EN
        exc_D     = D_valid ? exc_mem_q[rd_ptr_q] : 5'd0;
        wr_instr  = (F_exc != 5'd0) ? '0 : F_nInstr;
`else
        wr_instr  = F_nInstr;
`endif
    end

    // Next-state: flush wins over push/pop; pop latches the bubble pc
    always_comb begin
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        last_pc_d   = last_pc_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
`ifdef IF_ID_QUEUE_EXC_EN
        exc_mem_d   = exc_mem_q;
`endif
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                pc_mem_d[wr_ptr_q]    = F_pc;
                instr_mem_d[wr_ptr_q] = wr_instr;
`ifdef IF_ID_QUEUE_EXC_EN
                exc_mem_d[wr_ptr_q]   = F_exc;
`endif
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + AW'(1);
                last_pc_d = pc_mem_q[rd_ptr_q];
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            last_pc_q <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
`ifdef IF_ID_QUEUE_EXC_EN
                exc_mem_q[i]   <= '0;
`endif
            end
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            last_pc_q   <= last_pc_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
`ifdef IF_ID_QUEUE_EXC_EN
            exc_mem_q   <= exc_mem_d;
`endif
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: directed stimulus with a scoreboard queue for popped entries.
// Expected entries are queued when accepted; a monitor compares at each pop.
module tb_if_id_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        F_valid;
    logic        F_ready;
    logic [31:0] F_pc;
    logic [31:0] F_nInstr;
    logic        D_valid;
    logic        D_ready;
    logic [31:0] pc_D;
    logic [31:0] pcPlus4_D;
    logic [31:0] pcPlus8_D;
    logic [31:0] nInstr_D;
    logic [1:0]  count;
`ifdef IF_ID_QUEUE_EXC_EN
    logic [4:0]  F_exc;
    logic [4:0]  exc_D;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t exp_q[$];

    if_id_queue dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .F_valid   (F_valid),
        .F_ready   (F_ready),
        .F_pc      (F_pc),
        .F_nInstr  (F_nInstr),
`ifdef IF_ID_QUEUE_EXC_EN
        .F_exc     (F_exc),
        .exc_D     (exc_D),
`endif
        .D_valid   (D_valid),
        .D_ready   (D_ready),
        .pc_D      (pc_D),
        .pcPlus4_D (pcPlus4_D),
        .pcPlus8_D (pcPlus8_D),
        .nInstr_D  (nInstr_D),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next edge; compare head with scoreboard
    always @(negedge clk) begin
        if (!reset && !flush && D_valid && D_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got pc %h expected none", pc_D);
            end else begin
                chk("pop_pc", pc_D, exp_q[0].pc);
                chk("pop_instr", nInstr_D, exp_q[0].instr);
                chk("pop_pc4", pcPlus4_D, exp_q[0].pc + 32'd4);
                chk("pop_pc8", pcPlus8_D, exp_q[0].pc + 32'd8);
                void'(exp_q.pop_front());
            end
        end
    end

    // One cycle of stimulus; records accepted pushes into the scoreboard
    task automatic step(input logic fv, input logic [31:0] pc,
                        input logic [31:0] ins, input logic dr,
                        input logic fl, input logic rst);
        F_valid  = fv;
        F_pc     = pc;
        F_nInstr = ins;
        D_ready  = dr;
        flush    = fl;
        reset    = rst;
        @(negedge clk);
        #1;
        if (rst || fl) begin
            exp_q.delete();
        end else if (fv && F_ready) begin
            exp_q.push_back('{pc: pc, instr: ins});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_dvalid"}, {31'd0, D_valid}, 32'd0);
        chk({tag, "_ninstr"}, nInstr_D, 32'd0);
        chk({tag, "_pc"}, pc_D, 32'h3000);
        chk({tag, "_pc4"}, pcPlus4_D, 32'h3004);
        chk({tag, "_pc8"}, pcPlus8_D, 32'h3008);
        chk({tag, "_fready"}, {31'd0, F_ready}, 32'd1);
        chk({tag, "_count"}, {30'd0, count}, 32'd0);
    endtask

    initial begin
`ifdef IF_ID_QUEUE_EXC_EN
        F_exc = 5'd0;
`endif
        reset = 1'b1; flush = 1'b0; F_valid = 1'b0;
        F_pc = '0; F_nInstr = '0; D_ready = 1'b0;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk_reset_outputs("rst");

        // single push, visible one edge later, then popped
        step(1, 32'h3000, 32'h24010001, 1, 0, 0);
        chk("p1_dvalid", {31'd0, D_valid}, 32'd1);
        chk("p1_pc", pc_D, 32'h3000);
        chk("p1_pc8", pcPlus8_D, 32'h3008);
        chk("p1_instr", nInstr_D, 32'h24010001);
        step(0, 0, 0, 1, 0, 0);
        chk("p1e_dvalid", {31'd0, D_valid}, 32'd0);
        chk("p1e_instr", nInstr_D, 32'd0);
        chk("p1e_pc", pc_D, 32'h3000);

        // fill to full, third push refused, then drain in order
        step(1, 32'h3000, 32'h11110000, 0, 0, 0);
        chk("f1_fready", {31'd0, F_ready}, 32'd1);
        step(1, 32'h3004, 32'h11110004, 0, 0, 0);
        chk("f2_fready", {31'd0, F_ready}, 32'd0);
        chk("f2_count", {30'd0, count}, 32'd2);
        step(1, 32'h3008, 32'h11110008, 0, 0, 0);
        chk("f3_count", {30'd0, count}, 32'd2);
        chk("f3_head", pc_D, 32'h3000);
        step(0, 0, 0, 1, 0, 0);
        chk("d1_head", pc_D, 32'h3004);
        step(0, 0, 0, 1, 0, 0);
        chk("d2_count", {30'd0, count}, 32'd0);
        chk("d2_pc", pc_D, 32'h3004);

        // simultaneous push/pop at count=1 across pointer wrap
        step(1, 32'h300C, 32'h2222000C, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h3010 + 32'(4 * i), 32'h33330000 + 32'(i), 1, 0, 0);
            chk("pp_count", {30'd0, count}, 32'd1);
            chk("pp_head", pc_D, 32'h3010 + 32'(4 * i));
        end
        step(0, 0, 0, 1, 0, 0);
        chk("pp_drain_pc", pc_D, 32'h301C);

        // flush at count=2 discards everything incl. same-cycle push
        step(1, 32'h3100, 32'h44440000, 0, 0, 0);
        step(1, 32'h3104, 32'h44440004, 0, 0, 0);
        chk("fl_pre_count", {30'd0, count}, 32'd2);
        step(1, 32'h3108, 32'h44440008, 1, 1, 0);
        chk("fl_count", {30'd0, count}, 32'd0);
        chk("fl_dvalid", {31'd0, D_valid}, 32'd0);
        chk("fl_pc", pc_D, 32'h301C);
        step(0, 0, 0, 1, 0, 0);
        chk("fl_absent", {31'd0, D_valid}, 32'd0);

        // pc wrap in the adders, then reset while occupied
        step(1, 32'hFFFFFFFC, 32'h55550000, 0, 0, 0);
        chk("wr_pc", pc_D, 32'hFFFFFFFC);
        chk("wr_pc4", pcPlus4_D, 32'h00000000);
        chk("wr_pc8", pcPlus8_D, 32'h00000004);
        chk("wr_count", {30'd0, count}, 32'd1);
        step(0, 0, 0, 0, 0, 1);
        chk_reset_outputs("mid_rst");
        step(0, 0, 0, 0, 0, 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Parametrised IF/ID instruction buffer. Successor to the single-entry IF/ID pipeline register.
- Holds up to DEPTH fetched instructions between the fetch and decode stages, so fetch can keep running while decode is stalled.
- Uses valid/ready handshakes on both sides and a synchronous flush for branch/jump redirect.
- Presents the head entry to decode, together with its pc, pc+4 and pc+8.

Parameters:
- PC_W, 32, width of program-counter fields.
- INSTR_W, 32, width of the instruction word.
- DEPTH, 2, number of entries; power of two, ≥2.
- RESET_PC, 32'h00003000, pc_D value after reset while the queue is empty.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries (redirect).
- F_valid  input  1  fetch presents an entry this cycle.
- F_ready  output  1  queue can accept an entry (high exactly when not full).
- F_pc  input  PC_W  pc of the fetched instruction.
- F_nInstr  input  INSTR_W  fetched instruction word.
- D_valid  output  1  head entry valid.
- D_ready  input  1  decode consumes the head this cycle.
- pc_D  output  PC_W  head pc.
- pcPlus4_D  output  PC_W  pc_D+4.
- pcPlus8_D  output  PC_W  pc_D+8.
- nInstr_D  output  INSTR_W  head instruction; 0 (NOP) when D_valid=0.
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset. All state changes on the rising edge of clk.
- Reset values: count=0, D_valid=0, F_ready=1, nInstr_D=0, pc_D=RESET_PC, pcPlus4_D=RESET_PC+4, pcPlus8_D=RESET_PC+8; read/write pointers=0.
- Handshake events:
  - push = F_valid & F_ready.
  - pop = D_valid & D_ready.
- F_ready = (count != DEPTH). It has no combinational dependence on D_ready or flush.
- D_valid = (count != 0).
- Latency: an entry pushed at edge t is visible on the D side after edge t. There is no same-cycle fall-through from F to D.
- Ordering: strict FIFO. Write and read pointers wrap modulo DEPTH.
- Occupancy update:
  - push only: count+1.
  - pop only: count−1.
  - push and pop together: count unchanged, both pointers advance. Legal at any occupancy where F_ready=1.
  - When full (F_ready=0), a same-cycle pop does not allow a push in that cycle; F_valid is ignored.
- Empty queue:
  - nInstr_D forced to 0.
  - pc_D holds the pc of the most recently popped entry (RESET_PC if none since reset), so decode sees a stable bubble.
- Arithmetic: pcPlus4_D and pcPlus8_D are computed modulo 2^PC_W and wrap silently.
- Flush:
  - Takes effect on the next edge: count=0 and both pointers=0.
  - Any push or pop in the same cycle is discarded.
  - The last-popped pc is not updated by the flush.
  - Flush has priority over push/pop. Reset has priority over flush.
- F_valid with F_ready=0: no state change, and the input is not held internally.
- Reset asserted mid-operation: all entries are discarded and every output returns to its reset value on that edge.
- Outputs:
  - pc_D, nInstr_D and D_valid come directly from registered state (storage read at the read pointer), with no logic depending on D_ready.
  - pcPlus4_D and pcPlus8_D may be adders on pc_D.

Optional Feature:
- Macro: IF_ID_QUEUE_EXC_EN.
- Defined:
  - Adds input F_exc[4:0] (fetch exception code, 0 = none), stored per entry.
  - Adds output exc_D[4:0] (0 when empty or after reset/flush).
  - An entry with non-zero exc is stored with nInstr forced to 0, so decode sees NOP plus the exception code.
- Undefined: the ports and storage do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then idle → D_valid=0, nInstr_D=0, pc_D=0x3000, pcPlus4_D=0x3004, pcPlus8_D=0x3008, F_ready=1, count=0.
- Push pc=0x3000/instr=0x24010001 with D_ready=1 → one edge later D_valid=1, pc_D=0x3000, pcPlus8_D=0x3008. Popped next edge → D_valid=0, nInstr_D=0, pc_D stays 0x3000.
- D_ready=0, push 0x3000, 0x3004, 0x3008 on consecutive cycles with DEPTH=2 → F_ready=0 after second push; third is not accepted; count=2. Then D_ready=1 → pops 0x3000 then 0x3004 in order.
- count=1; push 0x3010 and pop 0x300C in the same cycle → count stays 1, head becomes 0x3010. Repeat 4 times to cover pointer wrap.
- count=2, flush=1 with F_valid=1 and D_ready=1 → next cycle count=0, D_valid=0, pushed entry absent, pc_D = pc last popped before the flush.
- Push pc=0xFFFFFFFC → pcPlus4_D=0x00000000, pcPlus8_D=0x00000004. Then assert reset with count=1 → all outputs at reset values next edge.
